dict_stream_decompressor: RTL and testbench

- Consumes the packed compressed instruction stream (fixed-width memory words) and emits one uncompressed value per cycle.
- Each packed entry is either a dictionary index or a raw literal.
- Sits directly upstream of the dictionary: drives its key lookup input and registers the combinationally returned value.
- Feeds decompressed instructions to the fetch/decode side through a valid/ready handshake.

---
 rtl/dict_stream_decompressor.sv | 96 +++++++++
 tb/tb_dict_stream_decompressor.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dict_stream_decompressor.sv
// Dictionary stream decompressor: unpacks a packed LSB-first stream of
// {flag,key} / {flag,literal} entries into one uncompressed value per cycle.
module dict_stream_decompressor #(
    parameter int unsigned KEY_WIDTH  = 4,
    parameter int unsigned VAL_WIDTH  = 32,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned BUF_WIDTH  = 2 * WORD_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WORD_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    output logic [KEY_WIDTH-1:0]       dict_key,
    input  logic [VAL_WIDTH-1:0]       dict_val,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [VAL_WIDTH-1:0]       out_data,
    output logic                       out_from_dict,
    output logic [$clog2(BUF_WIDTH):0] buf_count
);

    localparam int unsigned CNT_W = $clog2(BUF_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LEN_DICT = CNT_W'(1 + KEY_WIDTH);
    localparam logic [CNT_W-1:0] LEN_RAW  = CNT_W'(1 + VAL_WIDTH);
    localparam logic [CNT_W-1:0] ROOM     = CNT_W'(BUF_WIDTH - WORD_WIDTH);
    localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(WORD_WIDTH);

    logic [BUF_WIDTH-1:0] r_buf;
    logic [CNT_W-1:0]     r_count;
    logic                 r_out_valid;
    logic [VAL_WIDTH-1:0] r_out_data;
    logic                 r_out_from_dict;

    logic                 w_flag;
    logic [CNT_W-1:0]     w_len;
    logic                 w_complete;
    logic                 w_consume;
    logic                 w_accept;
    logic [CNT_W-1:0]     w_used;
    logic [CNT_W-1:0]     w_rem;
    logic [BUF_WIDTH-1:0] w_buf_next;
    logic [CNT_W-1:0]     w_count_next;

    // in_ready looks only at the registered count so it never depends on out_ready.
    assign in_ready      = (r_count <= ROOM) && !flush;
    assign dict_key      = r_buf[KEY_WIDTH:1];
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_from_dict = r_out_from_dict;
    assign buf_count     = r_count;

    // Entry decode, consumption and append position for the incoming word.
    always_comb begin
        w_flag       = r_buf[0];
        w_len        = w_flag ? LEN_DICT : LEN_RAW;
        w_complete   = (r_count != '0) && (r_count >= w_len);
        w_consume    = w_complete && (!r_out_valid || out_ready) && !flush;
        w_accept     = in_valid && in_ready;
        w_used       = w_consume ? w_len : '0;
        w_rem        = r_count - w_used;
        w_buf_next   = r_buf >> w_used;
        w_count_next = w_rem;
        if (w_accept) begin
            w_buf_next   = w_buf_next | (BUF_WIDTH'(in_data) << w_rem);
            w_count_next = w_rem + WORD_LEN;
        end
    end

    // Buffer is zeroed on flush so bits above the count stay clear for the OR-append.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf           <= '0;
            r_count         <= '0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_from_dict <= 1'b0;
        end else if (flush) begin
            r_buf       <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_buf   <= w_buf_next;
            r_count <= w_count_next;
            if (w_consume) begin
                r_out_data      <= w_flag ? dict_val : r_buf[VAL_WIDTH:1];
                r_out_from_dict <= w_flag;
                r_out_valid     <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dict_stream_decompressor.sv
// Self-checking bench for dict_stream_decompressor: bit-level reference decoder
// feeding an output scoreboard, a vector table and directed corner sequences.
module tb_dict_stream_decompressor;

    localparam int unsigned KW = 4;
    localparam int unsigned VW = 32;
    localparam int unsigned WW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          in_ready;
    logic [KW-1:0] dict_key;
    logic [VW-1:0] dict_val;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] out_data;
    logic          out_from_dict;
    logic [6:0]    buf_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [VW-1:0] data;
        logic          fd;
    } exp_t;

    exp_t exp_q[$];
    bit   bq[$];

    typedef struct {
        logic [WW-1:0] word;
        logic [KW-1:0] key;
        logic [VW-1:0] data;
        logic          fd;
        int unsigned   cnt;
    } vec_t;

    vec_t tv[5];

    dict_stream_decompressor #(
        .KEY_WIDTH (KW),
        .VAL_WIDTH (VW),
        .WORD_WIDTH(WW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .dict_key     (dict_key),
        .dict_val     (dict_val),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_from_dict(out_from_dict),
        .buf_count    (buf_count)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] f_dict(input logic [KW-1:0] k);
        if (k == 4'hA) return 32'hDEAD_BEEF;
        return 32'(k) * 32'h1111_1111;
    endfunction

    always_comb dict_val = f_dict(dict_key);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder: pull every complete entry out of the bit queue.
    function automatic void decode();
        logic [KW-1:0] k;
        logic [VW-1:0] v;
        exp_t e;
        forever begin
            if (bq.size() == 0) break;
            if (bq[0]) begin
                if (bq.size() < 1 + KW) break;
                for (int j = 0; j < KW; j++) k[j] = bq[1+j];
                e.data = f_dict(k);
                e.fd   = 1'b1;
                for (int j = 0; j < 1 + KW; j++) void'(bq.pop_front());
            end else begin
                if (bq.size() < 1 + VW) break;
                for (int j = 0; j < VW; j++) v[j] = bq[1+j];
                e.data = v;
                e.fd   = 1'b0;
                for (int j = 0; j < 1 + VW; j++) void'(bq.pop_front());
            end
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: sampled mid-cycle, so every value seen is what the next edge will use.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("in_ready_rule", 64'(in_ready), 64'((buf_count <= 7'd32) && !flush));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(out_data), 64'h1_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 64'(out_data), 64'(e.data));
                    chk("sb_from_dict", 64'(out_from_dict), 64'(e.fd));
                end
            end
            if (flush) begin
                bq.delete();
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                for (int i = 0; i < WW; i++) bq.push_back(in_data[i]);
                decode();
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        bq.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Hold a word until accepted; returns 1 time unit after the accepting edge.
    task automatic send_word(input logic [WW-1:0] w);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_valid;
        int stalls;
        int max_cnt;

        tv[0] = '{32'h0000_0015, 4'hA, 32'hDEAD_BEEF, 1'b1, 27};
        tv[1] = '{32'h0000_001F, 4'hF, 32'hFFFF_FFFF, 1'b1, 27};
        tv[2] = '{32'h0000_0003, 4'h1, 32'h1111_1111, 1'b1, 27};
        tv[3] = '{32'hABCD_001B, 4'hD, 32'hDDDD_DDDD, 1'b1, 27};
        tv[4] = '{32'h1234_561F, 4'hF, 32'hFFFF_FFFF, 1'b1, 27};

        // Reset values
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_buf_count", 64'(buf_count), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_from_dict", 64'(out_from_dict), 64'(0));

        // Single compressed entries from the vector table
        foreach (tv[i]) begin
            do_reset();
            out_ready = 1'b1;
            send_word(tv[i].word);
            chk("tv_dict_key", 64'(dict_key), 64'(tv[i].key));
            chk("tv_count_loaded", 64'(buf_count), 64'(32));
            chk("tv_valid_before", 64'(out_valid), 64'(0));
            step();
            chk("tv_out_valid", 64'(out_valid), 64'(1));
            chk("tv_out_data", 64'(out_data), 64'(tv[i].data));
            chk("tv_from_dict", 64'(out_from_dict), 64'(tv[i].fd));
            chk("tv_count", 64'(buf_count), 64'(tv[i].cnt));
            step();
            step();
            chk("tv_no_more", 64'(out_valid), 64'(0));
            chk("tv_drain", 64'(exp_q.size()), 64'(0));
        end

        // Raw entry straddling two words
        do_reset();
        out_ready = 1'b1;
        send_word(32'hFFFF_FFFE);
        step();
        chk("raw_wait_valid", 64'(out_valid), 64'(0));
        chk("raw_wait_count", 64'(buf_count), 64'(32));
        send_word(32'h0000_0001);
        chk("raw_count64", 64'(buf_count), 64'(64));
        step();
        chk("raw_valid", 64'(out_valid), 64'(1));
        chk("raw_data", 64'(out_data), 64'hFFFF_FFFF);
        chk("raw_from_dict", 64'(out_from_dict), 64'(0));
        chk("raw_count", 64'(buf_count), 64'(31));
        step();
        chk("raw_drain", 64'(exp_q.size()), 64'(0));

        // Backpressure: out_data held while out_ready is low
        do_reset();
        send_word(32'hFFFF_FFFF);
        step();
        chk("bp_first_valid", 64'(out_valid), 64'(1));
        repeat (5) step();
        chk("bp_hold_valid", 64'(out_valid), 64'(1));
        chk("bp_hold_data", 64'(out_data), 64'hFFFF_FFFF);
        chk("bp_hold_count", 64'(buf_count), 64'(27));
        chk("bp_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) n_valid++;
        end
        chk("bp_consecutive", 64'(n_valid), 64'(5));
        chk("bp_count_end", 64'(buf_count), 64'(2));
        step();
        chk("bp_idle", 64'(out_valid), 64'(0));
        chk("bp_drain", 64'(exp_q.size()), 64'(0));

        // Buffer full: in_ready drops and no word is lost
        do_reset();
        stalls  = 0;
        max_cnt = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_word($urandom);
            end
            begin
                repeat (12) begin
                    @(negedge clk);
                    if (in_valid && !in_ready) stalls++;
                    if (int'(buf_count) > max_cnt) max_cnt = int'(buf_count);
                end
                out_ready = 1'b1;
            end
        join
        chk("full_stalled", 64'(stalls > 0), 64'(1));
        chk("full_over32", 64'(max_cnt > 32), 64'(1));
        repeat (30) step();
        chk("full_drain", 64'(exp_q.size()), 64'(0));

        // Flush mid-entry
        do_reset();
        out_ready = 1'b1;
        send_word(32'hFFFF_FFFE);
        chk("fl_count_before", 64'(buf_count), 64'(32));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_count", 64'(buf_count), 64'(0));
        chk("fl_valid", 64'(out_valid), 64'(0));
        send_word(32'h0000_0015);
        chk("fl_dict_key", 64'(dict_key), 64'(4'hA));
        step();
        chk("fl_out_valid", 64'(out_valid), 64'(1));
        chk("fl_out_data", 64'(out_data), 64'hDEAD_BEEF);
        chk("fl_from_dict", 64'(out_from_dict), 64'(1));
        chk("fl_out_count", 64'(buf_count), 64'(27));
        step();
        chk("fl_drain", 64'(exp_q.size()), 64'(0));

        // Asynchronous reset between edges
        do_reset();
        send_word(32'h0000_0015);
        step();
        chk("ar_valid_before", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'(0));
        chk("ar_count", 64'(buf_count), 64'(0));
        do_reset();
        chk("ar_in_ready", 64'(in_ready), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
